// File: rtl/noc_pkg.sv
// Shared NoC constants for the output-VC status path and the input-port request mask.
// Credit counter width derives from the downstream buffer depth.
package noc_pkg;

    localparam int VC_NUM     = 4;
    localparam int BUFF_DEPTH = 4;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int CNT_W = clog2(BUFF_DEPTH + 1);

    // Bit positions inside each VC's 2-bit status field.
    localparam int ST_FULL  = 1;
    localparam int ST_NFULL = 0;

endpackage

// File: rtl/ovc_credit_cnt.sv
// One output VC: downstream free-slot credit counter, ownership bit, status and
// availability bits, and a single-cycle local protocol error pulse.
module ovc_credit_cnt
    import noc_pkg::*;
#(
    parameter int BUFF_DEPTH = noc_pkg::BUFF_DEPTH,
    parameter int CNT_W      = noc_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec,
    input  logic       inc,
    input  logic       tail,
    input  logic       alloc,
    output logic [1:0] status,
    output logic       available,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFF_DEPTH);

    logic [CNT_W-1:0] cnt;
    logic             owned;
    logic             dec_only;
    logic             inc_only;
    logic             underflow;
    logic             overflow;
    logic             release_vc;

    always_comb begin
        dec_only   = dec & ~inc;
        inc_only   = inc & ~dec;
        underflow  = dec_only & (cnt == '0);
        overflow   = inc_only & (cnt == CNT_MAX);
        release_vc = dec & tail;
        err        = underflow | overflow | (alloc & release_vc) | (alloc & owned) | (dec & ~owned);
    end

    // Counter saturates at both ends; a same-cycle flit and credit net to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= CNT_MAX;
            owned <= 1'b0;
        end else begin
            if (dec_only && !underflow) begin
                cnt <= cnt - 1'b1;
            end else if (inc_only && !overflow) begin
                cnt <= cnt + 1'b1;
            end
            if (alloc) begin
                owned <= 1'b1;
            end else if (release_vc) begin
                owned <= 1'b0;
            end
        end
    end

    always_comb begin
        status           = 2'b00;
        status[ST_FULL]  = (cnt == '0);
        status[ST_NFULL] = (cnt == CNT_W'(1));
        available        = ~owned & (cnt != '0);
    end

endmodule

// File: rtl/ovc_status_gen.sv
// Output-port OVC status generator: per-VC credit/ownership tracking feeding the
// {full, nearly_full} status and availability vectors used by every request mask.
module ovc_status_gen
    import noc_pkg::*;
#(
    parameter int VC_NUM     = noc_pkg::VC_NUM,
    parameter int BUFF_DEPTH = noc_pkg::BUFF_DEPTH,
    parameter int CNT_W      = noc_pkg::clog2(BUFF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flit_wr,
    input  logic [VC_NUM-1:0]     flit_vc,
    input  logic                  flit_tail,
    input  logic                  credit_in,
    input  logic [VC_NUM-1:0]     credit_vc,
    input  logic [VC_NUM-1:0]     ovc_alloc,
    output logic [2*VC_NUM-1:0]   ovc_status,
    output logic [VC_NUM-1:0]     ovc_available,
    output logic                  ovc_any_available,
    output logic                  proto_err
);

    // Flits and credits arrive unconditionally, one per cycle each: there is no
    // valid/ready handshake on this block, so nothing can be back-pressured.
    logic              flit_ok;
    logic              credit_ok;
    logic              flit_bad;
    logic              credit_bad;
    logic [VC_NUM-1:0] dec_vec;
    logic [VC_NUM-1:0] inc_vec;
    logic [VC_NUM-1:0] local_err;
    logic              err_now;

    // A malformed VC select is dropped entirely so it cannot corrupt any counter.
    always_comb begin
        flit_ok    = flit_wr & $onehot(flit_vc);
        credit_ok  = credit_in & $onehot(credit_vc);
        flit_bad   = flit_wr & ~$onehot(flit_vc);
        credit_bad = credit_in & ~$onehot(credit_vc);
        dec_vec    = {VC_NUM{flit_ok}} & flit_vc;
        inc_vec    = {VC_NUM{credit_ok}} & credit_vc;
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        ovc_credit_cnt #(
            .BUFF_DEPTH (BUFF_DEPTH),
            .CNT_W      (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .dec       (dec_vec[v]),
            .inc       (inc_vec[v]),
            .tail      (flit_tail),
            .alloc     (ovc_alloc[v]),
            .status    (ovc_status[2*v +: 2]),
            .available (ovc_available[v]),
            .err       (local_err[v])
        );
    end

    always_comb begin
        err_now           = (|local_err) | flit_bad | credit_bad;
        ovc_any_available = |ovc_available;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (err_now) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ovc_status_gen.sv
// Directed bench for ovc_status_gen: a reference model pushes the expected output
// word per cycle into a queue, popped and compared one cycle later.
module tb_ovc_status_gen;

    localparam int VC = 4;
    localparam int DEPTH = 4;
    localparam int W = 2 + 3 * VC;

    logic            clk;
    logic            reset;
    logic            flit_wr;
    logic [VC-1:0]   flit_vc;
    logic            flit_tail;
    logic            credit_in;
    logic [VC-1:0]   credit_vc;
    logic [VC-1:0]   ovc_alloc;
    logic [2*VC-1:0] ovc_status;
    logic [VC-1:0]   ovc_available;
    logic            ovc_any_available;
    logic            proto_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    int cnt_m[VC];
    bit owned_m[VC];
    bit err_m;

    ovc_status_gen dut (
        .clk               (clk),
        .reset             (reset),
        .flit_wr           (flit_wr),
        .flit_vc           (flit_vc),
        .flit_tail         (flit_tail),
        .credit_in         (credit_in),
        .credit_vc         (credit_vc),
        .ovc_alloc         (ovc_alloc),
        .ovc_status        (ovc_status),
        .ovc_available     (ovc_available),
        .ovc_any_available (ovc_any_available),
        .proto_err         (proto_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] observed();
        return {proto_err, ovc_any_available, ovc_available, ovc_status};
    endfunction

    function automatic logic [W-1:0] model_word();
        logic [2*VC-1:0] st;
        logic [VC-1:0]   av;
        for (int v = 0; v < VC; v++) begin
            st[2*v+1] = (cnt_m[v] == 0);
            st[2*v]   = (cnt_m[v] == 1);
            av[v]     = !owned_m[v] && (cnt_m[v] != 0);
        end
        return {err_m, |av, av, st};
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VC; v++) begin
            cnt_m[v]   = DEPTH;
            owned_m[v] = 1'b0;
        end
        err_m = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_field(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_inputs();
        flit_wr   = 1'b0;
        flit_vc   = '0;
        flit_tail = 1'b0;
        credit_in = 1'b0;
        credit_vc = '0;
        ovc_alloc = '0;
    endtask

    // driver: one cycle of stimulus, model update, expected push, then pop/compare
    task automatic step(input string tag, input logic fw, input logic [VC-1:0] fv, input logic ft,
                        input logic ci, input logic [VC-1:0] cv, input logic [VC-1:0] al);
        bit fok;
        bit cok;
        bit d;
        bit i;
        @(negedge clk);
        flit_wr   = fw;
        flit_vc   = fv;
        flit_tail = ft;
        credit_in = ci;
        credit_vc = cv;
        ovc_alloc = al;
        fok = fw && $onehot(fv);
        cok = ci && $onehot(cv);
        if (fw && !$onehot(fv)) err_m = 1'b1;
        if (ci && !$onehot(cv)) err_m = 1'b1;
        for (int v = 0; v < VC; v++) begin
            d = fok && fv[v];
            i = cok && cv[v];
            if (d && !i) begin
                if (cnt_m[v] == 0) err_m = 1'b1;
                else cnt_m[v]--;
            end else if (i && !d) begin
                if (cnt_m[v] == DEPTH) err_m = 1'b1;
                else cnt_m[v]++;
            end
            if (d && !owned_m[v]) err_m = 1'b1;
            if (al[v]) begin
                if (owned_m[v]) err_m = 1'b1;
                if (d && ft) err_m = 1'b1;
                owned_m[v] = 1'b1;
            end else if (d && ft) begin
                owned_m[v] = 1'b0;
            end
        end
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        check_word(tag, observed(), exp_q.pop_front());
        idle_inputs();
    endtask

    task automatic flit(input string tag, input logic [VC-1:0] fv, input logic ft);
        step(tag, 1'b1, fv, ft, 1'b0, '0, '0);
    endtask

    task automatic credit(input string tag, input logic [VC-1:0] cv);
        step(tag, 1'b0, '0, 1'b0, 1'b1, cv, '0);
    endtask

    task automatic alloc(input string tag, input logic [VC-1:0] al);
        step(tag, 1'b0, '0, 1'b0, 1'b0, '0, al);
    endtask

    // asynchronous reset asserted between edges; outputs must clear at once
    task automatic apply_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        model_reset();
        exp_q.push_back({1'b0, 1'b1, {VC{1'b1}}, {2*VC{1'b0}}});
        #1;
        check_word(tag, observed(), exp_q.pop_front());
        #2;
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #2;
        apply_reset("reset_initial");

        // 1. idle after reset
        step("idle", 1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_field("idle_status", ovc_status, 8'h00);

        // 2. fill VC1
        alloc("alloc_vc1", 4'b0010);
        check_field("vc1_avail_owned", {7'b0, ovc_available[1]}, 8'h00);
        flit("fill_1", 4'b0010, 1'b0);
        flit("fill_2", 4'b0010, 1'b0);
        check_field("vc1_not_nfull_yet", {6'b0, ovc_status[3:2]}, 8'h00);
        flit("fill_3", 4'b0010, 1'b0);
        check_field("vc1_nearly_full", {6'b0, ovc_status[3:2]}, 8'h01);
        flit("fill_4", 4'b0010, 1'b0);
        check_field("vc1_full", {6'b0, ovc_status[3:2]}, 8'h02);
        check_field("vc1_avail_full", {7'b0, ovc_available[1]}, 8'h00);

        // 3. simultaneous flit and credit
        credit("vc1_credit_to_1", 4'b0010);
        step("vc1_flit_and_credit", 1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, '0);
        check_field("vc1_net_zero", {6'b0, ovc_status[3:2]}, 8'h01);
        credit("vc1_credit_to_2", 4'b0010);
        check_field("vc1_cnt2_status", {6'b0, ovc_status[3:2]}, 8'h00);

        // 4. tail release on VC2
        alloc("alloc_vc2", 4'b0100);
        check_field("vc2_owned_unavail", {7'b0, ovc_available[2]}, 8'h00);
        flit("vc2_tail", 4'b0100, 1'b1);
        check_field("vc2_released_avail", {7'b0, ovc_available[2]}, 8'h01);
        credit("vc2_credit_back", 4'b0100);
        check_field("no_err_yet", {7'b0, proto_err}, 8'h00);

        // 5a. underflow on VC0
        alloc("alloc_vc0", 4'b0001);
        for (int k = 0; k < DEPTH; k++) flit("drain_vc0", 4'b0001, 1'b0);
        flit("vc0_underflow", 4'b0001, 1'b0);
        check_field("underflow_err", {7'b0, proto_err}, 8'h01);
        check_field("underflow_held", {6'b0, ovc_status[1:0]}, 8'h02);
        step("err_sticky", 1'b0, '0, 1'b0, 1'b0, '0, '0);
        check_field("err_sticky_val", {7'b0, proto_err}, 8'h01);
        apply_reset("reset_after_underflow");

        // 5b. overflow on VC3
        credit("vc3_overflow", 4'b1000);
        check_field("overflow_err", {7'b0, proto_err}, 8'h01);
        apply_reset("reset_after_overflow");

        // 5c. non-one-hot flit_vc
        alloc("alloc_vc01", 4'b0011);
        for (int k = 0; k < DEPTH - 1; k++) begin
            flit("drain_vc0_b", 4'b0001, 1'b0);
            flit("drain_vc1_b", 4'b0010, 1'b0);
        end
        flit("flit_vc_0011", 4'b0011, 1'b0);
        check_field("bad_flit_err", {7'b0, proto_err}, 8'h01);
        check_field("bad_flit_held", {4'b0, ovc_status[3:0]}, 8'h05);
        apply_reset("reset_after_bad_flit");

        // 5d. non-one-hot credit_vc
        alloc("alloc_vc0_c", 4'b0001);
        flit("vc0_one_out", 4'b0001, 1'b0);
        credit("credit_vc_1101", 4'b1101);
        check_field("bad_credit_err", {7'b0, proto_err}, 8'h01);
        apply_reset("reset_after_bad_credit");

        // 6. mid-operation reset with VC3 owned and nearly full
        alloc("alloc_vc3", 4'b1000);
        for (int k = 0; k < DEPTH - 1; k++) flit("drain_vc3", 4'b1000, 1'b0);
        check_field("vc3_nearly_full", {6'b0, ovc_status[7:6]}, 8'h01);
        apply_reset("reset_mid_op");
        step("idle_after_reset", 1'b0, '0, 1'b0, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
